// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left, parallel load,
// with a remaining-bit counter and done pulse. Optional rotate: UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg #(
  parameter  int W  = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  pi,
  input  logic          sir,
  input  logic          sil,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic          rot,
`endif
  output logic [W-1:0]  po,
  output logic          sor,
  output logic          sol,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [W-1:0]  po_q, po_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          ins_right, ins_left;

  // Bits entering the word on each shift direction; rotate recirculates the outgoing bit.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign ins_right = rot ? po_q[0]   : sir;
  assign ins_left  = rot ? po_q[W-1] : sil;
`else
  assign ins_right = sir;
  assign ins_left  = sil;
`endif

  always_comb begin
    po_d   = po_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          po_d = po_q;
        end
        MODE_RIGHT, MODE_LEFT: begin
          if (mode == MODE_RIGHT) begin
            po_d = {ins_right, po_q[W-1:1]};
          end else begin
            po_d = {po_q[W-2:0], ins_left};
          end
          // Counter saturates at zero; done fires only on the 1 -> 0 transition.
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
          end
        end
        MODE_LOAD: begin
          po_d  = pi;
          cnt_d = CW'(W);
        end
        default: begin
          po_d = po_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      po_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      po_q   <= po_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign po   = po_q;
  assign cnt  = cnt_q;
  assign done = done_q;
  assign sor  = po_q[0];
  assign sol  = po_q[W-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized + directed bench for univ_shift_reg at W=4 and W=8 against an
// arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] pi8 = 8'h00;
  logic [3:0] pi4;
  logic       sir = 1'b0;
  logic       sil = 1'b0;
  logic       rot = 1'b0;

  logic [3:0] po4;
  logic       sor4, sol4, done4;
  logic [2:0] cnt4;
  logic [7:0] po8;
  logic       sor8, sol8, done8;
  logic [3:0] cnt8;

  int n_cmp = 0;
  int n_bad = 0;
  int m_po4 = 0, m_cnt4 = 0, m_dn4 = 0;
  int m_po8 = 0, m_cnt8 = 0, m_dn8 = 0;
  int done4_seen = 0;
  int done8_seen = 0;

  assign pi4 = pi8[3:0];

  always #5 clk = ~clk;

  univ_shift_reg #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .pi(pi4), .sir(sir), .sil(sil),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot(rot),
`endif
    .po(po4), .sor(sor4), .sol(sol4), .cnt(cnt4), .done(done4)
  );

  univ_shift_reg #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .pi(pi8), .sir(sir), .sil(sil),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot(rot),
`endif
    .po(po8), .sor(sor8), .sol(sol8), .cnt(cnt8), .done(done8)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the register as an integer word, the counter as a plain count.
  function automatic void ref_step(input int w, input bit r, input bit e, input int m,
                                   input int p, input bit sr, input bit sl, input bit rt,
                                   inout int po, inout int cnt, output int dn);
    int mask;
    int ins;
    mask = (1 << w) - 1;
    dn = 0;
    if (r) begin
      po = 0;
      cnt = 0;
    end else if (e) begin
      if (m == 1 || m == 2) begin
        if (m == 1) begin
          ins = rt ? (po % 2) : int'(sr);
          po = (po / 2) + ins * (1 << (w - 1));
        end else begin
          ins = rt ? (po / (1 << (w - 1))) % 2 : int'(sl);
          po = (po * 2 + ins) & mask;
        end
        if (cnt > 0) begin
          cnt = cnt - 1;
          dn = (cnt == 0) ? 1 : 0;
        end
      end else if (m == 3) begin
        po = p & mask;
        cnt = w;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input logic [1:0] m, input logic [7:0] p,
                     input bit sr, input bit sl, input bit rt);
    bit rt_eff;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    rt_eff = rt;
`else
    rt_eff = 1'b0;
`endif
    rst = r; en = e; mode = m; pi8 = p; sir = sr; sil = sl; rot = rt;
    @(posedge clk);
    ref_step(4, r, e, int'(m), int'(p), sr, sl, rt_eff, m_po4, m_cnt4, m_dn4);
    ref_step(8, r, e, int'(m), int'(p), sr, sl, rt_eff, m_po8, m_cnt8, m_dn8);
    #1;
    check("po4", po4, m_po4);
    check("cnt4", cnt4, m_cnt4);
    check("done4", done4, m_dn4);
    check("sor4", sor4, m_po4 % 2);
    check("sol4", sol4, (m_po4 / 8) % 2);
    check("po8", po8, m_po8);
    check("cnt8", cnt8, m_cnt8);
    check("done8", done8, m_dn8);
    check("sor8", sor8, m_po8 % 2);
    check("sol8", sol8, (m_po8 / 128) % 2);
    if (done4 === 1'b1) done4_seen++;
    if (done8 === 1'b1) done8_seen++;
  endtask

  initial begin
    bit exp_sor [5];
    exp_sor = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with a load pending: reset wins every cycle.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 2'b11, 8'h0D, 1'b0, 1'b0, 1'b0);
      check("rst_po4", po4, 0);
      check("rst_cnt4", cnt4, 0);
      check("rst_done4", done4, 0);
    end

    // Load 1101 then four right shifts with sir=0.
    done4_seen = 0;
    cyc(1'b0, 1'b1, 2'b11, 8'h0D, 1'b0, 1'b0, 1'b0);
    check("piso_sor0", sor4, exp_sor[0]);
    check("piso_cnt0", cnt4, 4);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
      check("piso_sor", sor4, exp_sor[i]);
      check("piso_cnt", cnt4, 4 - i);
      check("piso_done", done4, (i == 4) ? 1 : 0);
    end
    check("piso_po_end", po4, 0);
    check("piso_done_count", done4_seen, 1);

    // SIPO on the 8-bit instance from a cleared register.
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    done8_seen = 0;
    begin
      bit pat [8];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, pat[i], 1'b0);
    end
    check("sipo_po8", po8, 8'hB2);
    check("sipo_cnt8", cnt8, 0);
    check("sipo_done_count", done8_seen, 0);

    // Enable low freezes even with a shift requested; hold keeps everything.
    cyc(1'b0, 1'b1, 2'b11, 8'h08, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
    check("hold_po4", po4, 8);
    check("hold_cnt4", cnt4, 4);

    // Reload mid-sequence restarts the count without a done.
    done4_seen = 0;
    cyc(1'b0, 1'b1, 2'b11, 8'h0D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b11, 8'h06, 1'b0, 1'b0, 1'b0);
    check("reload_po4", po4, 6);
    check("reload_cnt4", cnt4, 4);
    check("reload_done_count", done4_seen, 0);

    // Reset mid-sequence.
    cyc(1'b0, 1'b1, 2'b11, 8'h0D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    check("midrst_po4", po4, 0);
    check("midrst_cnt4", cnt4, 0);
    check("midrst_done_count", done4_seen, 0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    done4_seen = 0;
    cyc(1'b0, 1'b1, 2'b11, 8'h0D, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rot_po4", po4, 13);
    check("rot_done_count", done4_seen, 1);
`endif

    // Randomized traffic; reset kept rare so shift sequences run to completion.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
          2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the successor to the fixed 4-bit PIPO register. It supports hold, shift-right, shift-left and parallel load on one registered word. A remaining-bit counter and a `done` pulse let it act as a PISO/SIPO converter in the serial-link datapath. Optional rotate mode is compile-time selectable.

## Interface
- `W`, default 4: register width in bits; legal range 2..32.
- `CW`, default `$clog2(W+1)`: counter width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  clock enable; 0 freezes all state.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `pi`  in  W  parallel input, sampled on load.
- `sir`  in  1  serial input entering at MSB on shift right.
- `sil`  in  1  serial input entering at LSB on shift left.
- `rot`  in  1  rotate select; present only with `UNIV_SHIFT_REG_ROTATE_EN`.
- `po`  out  W  registered parallel output.
- `sor`  out  1  serial out, right side: equals `po[0]`, combinational from the register.
- `sol`  out  1  serial out, left side: equals `po[W-1]`, combinational from the register.
- `cnt`  out  CW  registered count of valid bits remaining since the last load.
- `done`  out  1  registered one-cycle pulse when `cnt` reaches 0 by shifting.

## Operation
- Reset value of every output: `po`=0, `cnt`=0, `done`=0, so `sor`=`sol`=0.
- Priority per edge: `rst` first, then `en`=0, then `mode`.
- While `en`=0: `po` and `cnt` hold, and `done` is 0.
- Hold (00): `po` and `cnt` are unchanged; `done`=0.
- Shift right (01): `po` <= {`sir`, `po[W-1:1]`}.
- Shift left (10): `po` <= {`po[W-2:0]`, `sil`}.
- Load (11): `po` <= `pi`; `cnt` <= W; `done`=0.
- Counter on either shift:
  - `cnt` decrements when nonzero and saturates at 0.
  - `done`=1 only on the edge where `cnt` moves 1 -> 0.
  - Shifts with `cnt`=0 still move data; `cnt` stays 0 and `done` stays 0.
- Load while a shift sequence is in progress: `cnt` restarts at W and no `done` is issued for the aborted sequence.
- `mode` is fully decoded; there are no illegal encodings.

## Timing
- Single-cycle latency: an input sampled at edge N is visible on `po`, `cnt` and `done` after edge N.
- `sor` and `sol` follow `po` combinationally, with no extra cycle.
- A full PISO word takes W shifts after a load. The first serial bit (`sor`=`pi[0]`) is available in the cycle right after the load edge.
- `done` asserts in the cycle after the W-th shift edge.
- Reset mid-sequence: the register clears on that edge; `done` is not issued and `cnt`=0.
- Simultaneous `rst`=1 and load: reset wins.

## Configuration
- Macro: `UNIV_SHIFT_REG_ROTATE_EN`.
- Defined:
  - The `rot` port exists.
  - With `rot`=1, shift right inserts `po[0]` at the MSB instead of `sir`.
  - With `rot`=1, shift left inserts `po[W-1]` at the LSB instead of `sil`.
  - Counter and `done` behave exactly as for a normal shift.
- Undefined: no `rot` port, and shifts always use `sir`/`sil`.

## Test plan
- Reset with W=4: set `rst`=1 for 5 cycles with `pi`=1101 and `mode`=11 -> `po`=0000, `cnt`=0, `done`=0 throughout.
- Load then shift right: load 1101, then 4 shifts right with `sir`=0.
  - `sor` sequence is 1,0,1,1.
  - `po` ends at 0000.
  - `cnt` goes 4,3,2,1,0.
  - `done` is high only after the 4th shift.
- Shift left: from 0000 with W=8, shift left with `sil` pattern 1,0,1,1,0,0,1,0 -> `po`=10110010; `cnt` stays 0; `done` never pulses.
- Enable and hold: load 1000, then 2 cycles with `en`=0 and `mode`=01, then 1 cycle of hold -> `po`=1000 and `cnt`=4 unchanged.
- Mid-sequence interrupts:
  - Load 1101, shift twice, then reload 0110 -> `cnt`=4 and no `done` issued.
  - Load 1101, shift twice, then assert `rst` -> `po`=0000, `cnt`=0, no `done`.
- Rotate (macro defined): load 1101 with `rot`=1, then 4 shifts right -> `po` returns to 1101 and `done` pulses once.
